// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812B serial receiver/decoder; define WS2812_RX_PASSTHRU_EN to add the chained dout output
module ws2812_rx #(
    parameter int THRESH       = 8,
    parameter int MIN_HIGH     = 2,
    parameter int MAX_HIGH     = 20,
    parameter int RESET_CYCLES = 600,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pix_data,
    output logic [7:0]  pix_idx,
    output logic        pix_valid,
    output logic        frame_done,
    output logic [7:0]  frame_pixels,
    output logic        err,
`ifdef WS2812_RX_PASSTHRU_EN
    output logic        dout,
`endif
    output logic        busy
);
    localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] MINH = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] MAXH = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] RC   = CNT_W'(RESET_CYCLES);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic             s1_q, ds_q, dp_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [22:0]      word_q, word_d;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic [23:0]      pix_data_q, pix_data_d;
    logic [7:0]       pix_idx_q, pix_idx_d, frame_pixels_q, frame_pixels_d;
    logic             pix_valid_q, pix_valid_d, frame_done_q, frame_done_d, err_q, err_d;
    logic             rise, fall, bit_v;

    assign rise  = ds_q & ~dp_q;
    assign fall  = ~ds_q & dp_q;
    assign bit_v = hcnt_q >= THR;

    // Next-state: pulse measurement, bit classification, word assembly and frame-gap detection
    always_comb begin
        state_d        = state_q;
        hcnt_d         = hcnt_q;
        lcnt_d         = lcnt_q;
        word_d         = word_q;
        bitcnt_d       = bitcnt_q;
        pcnt_d         = pcnt_q;
        pix_data_d     = pix_data_q;
        pix_idx_d      = pix_idx_q;
        frame_pixels_d = frame_pixels_q;
        pix_valid_d    = 1'b0;
        frame_done_d   = 1'b0;
        err_d          = 1'b0;
        case (state_q)
            SYNC: begin
                lcnt_d = ds_q ? '0 : lcnt_q + 1'b1;
                if (!ds_q && (lcnt_q + 1'b1) >= RC) begin
                    state_d = IDLE;
                    lcnt_d  = '0;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                end
            end
            HIGH: begin
                if (fall) begin
                    if (hcnt_q < MINH || hcnt_q > MAXH) begin
                        err_d    = 1'b1;
                        bitcnt_d = '0;
                        pcnt_d   = '0;
                        lcnt_d   = '0;
                        state_d  = SYNC;
                    end else begin
                        state_d = LOW;
                        lcnt_d  = CNT_W'(1);
                        if (bitcnt_q == 5'd23) begin
                            pix_data_d  = {bit_v, word_q};
                            pix_valid_d = 1'b1;
                            pix_idx_d   = pcnt_q;
                            bitcnt_d    = '0;
                            pcnt_d      = (&pcnt_q) ? pcnt_q : pcnt_q + 1'b1;
                        end else begin
                            word_d[bitcnt_q] = bit_v;
                            bitcnt_d         = bitcnt_q + 1'b1;
                        end
                    end
                end else begin
                    hcnt_d = (&hcnt_q) ? hcnt_q : hcnt_q + 1'b1;
                end
            end
            LOW: begin
                if (lcnt_q >= RC) begin
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pcnt_q;
                    err_d          = bitcnt_q != 5'd0;
                    pcnt_d         = '0;
                    bitcnt_d       = '0;
                    state_d        = IDLE;
                end else if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = CNT_W'(1);
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // State, synchroniser and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= SYNC;
            s1_q           <= 1'b0;
            ds_q           <= 1'b0;
            dp_q           <= 1'b0;
            hcnt_q         <= '0;
            lcnt_q         <= '0;
            word_q         <= '0;
            bitcnt_q       <= '0;
            pcnt_q         <= '0;
            pix_data_q     <= '0;
            pix_idx_q      <= '0;
            frame_pixels_q <= '0;
            pix_valid_q    <= 1'b0;
            frame_done_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            s1_q           <= din;
            ds_q           <= s1_q;
            dp_q           <= ds_q;
            hcnt_q         <= hcnt_d;
            lcnt_q         <= lcnt_d;
            word_q         <= word_d;
            bitcnt_q       <= bitcnt_d;
            pcnt_q         <= pcnt_d;
            pix_data_q     <= pix_data_d;
            pix_idx_q      <= pix_idx_d;
            frame_pixels_q <= frame_pixels_d;
            pix_valid_q    <= pix_valid_d;
            frame_done_q   <= frame_done_d;
            err_q          <= err_d;
        end
    end

    assign pix_data     = pix_data_q;
    assign pix_idx      = pix_idx_q;
    assign pix_valid    = pix_valid_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign err          = err_q;
    assign busy         = state_q == HIGH || state_q == LOW;

`ifdef WS2812_RX_PASSTHRU_EN
    logic pt_q, pt_d, dout_q;

    assign pt_d = (frame_done_d | err_d) ? 1'b0 : (pix_valid_d && pcnt_q == 8'd0) ? 1'b1 : pt_q;

    // Pass-through: the first pixel is consumed, later pixels are forwarded one clk behind ds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pt_q   <= 1'b0;
            dout_q <= 1'b0;
        end else begin
            pt_q   <= pt_d;
            dout_q <= pt_d & ds_q;
        end
    end

    assign dout = dout_q;
`endif
endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Single-wire WS2812B-style receiver/decoder, clocked at the 12 MHz system clock.
- Samples the neopixel data line, classifies each high pulse as a 0 or 1 by width, assembles 24-bit pixel words LSB-first, and detects the inter-frame latch gap.
- Used as a loopback checker and sniffer for the pixel transmitter's serial output, and as a front-end for any board that accepts a neopixel stream.

Parameters:
- THRESH, 8: high-pulse width in clk cycles at or above which a bit decodes as 1.
- MIN_HIGH, 2: shortest legal high pulse in cycles; shorter is a glitch.
- MAX_HIGH, 20: longest legal high pulse in cycles; longer is an error.
- RESET_CYCLES, 600: continuous low cycles that mark frame end (50 us at 12 MHz).
- CNT_W, 16: width of the high and low pulse counters; must hold RESET_CYCLES.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data line, asynchronous to clk.
- pix_data  output  24  last decoded pixel; bit0 = first bit received. Layout [23:16]=B, [15:8]=R, [7:0]=G.
- pix_idx  output  8  index of pix_data within the current frame, 0-based.
- pix_valid  output  1  one-cycle strobe; pix_data and pix_idx are new this cycle.
- frame_done  output  1  one-cycle strobe at frame end.
- frame_pixels  output  8  count of complete pixels in the frame just ended.
- err  output  1  one-cycle strobe on a protocol error.
- busy  output  1  high while state is HIGH or LOW.

Behaviour:
- Input synchronisation: 2-FF synchroniser on din gives ds. Edges are detected on ds against its previous value. Total latency from a din edge to edge detection is 3 clk.
- Reset values: all outputs 0, state SYNC, all counters 0.
- SYNC: ignores edges. Counts consecutive low cycles; any high clears the count. When the count reaches RESET_CYCLES, go to IDLE. No frame_done is raised.
- IDLE: on a rising edge, go to HIGH with hcnt=1.
- HIGH: hcnt increments each cycle and saturates at all-ones. On a falling edge, classify the pulse:
  - hcnt < MIN_HIGH or hcnt > MAX_HIGH: pulse err, discard the partial word, clear bit and pixel counts, go to SYNC.
  - Otherwise: bit = (hcnt >= THRESH). Shift into the word at position bitcnt. bitcnt++. Go to LOW with lcnt=1.
- Word completion: when the 24th bit is accepted, on the same cycle as the falling-edge detection:
  - pix_data is loaded and pix_valid pulses.
  - pix_idx = current pixel count.
  - bitcnt returns to 0.
  - Pixel count increments, saturating at 255. At saturation, pix_idx stays 255 and frame_pixels reports 255.
- LOW: lcnt increments each cycle.
  - Rising edge before RESET_CYCLES: go to HIGH with hcnt=1. A long low gap below the threshold is legal.
  - lcnt reaching RESET_CYCLES, bitcnt == 0: pulse frame_done, load frame_pixels, clear pixel count, go to IDLE.
  - lcnt reaching RESET_CYCLES, bitcnt != 0: also pulse err on the same cycle and discard the partial bits.
- Simultaneous events: err and frame_done may assert together. pix_valid never coincides with frame_done, because they are decided in different states.
- rst asserted mid-frame returns the block to SYNC. Any partial word is lost and no strobes are emitted.
- Strobes are exactly one cycle wide. pix_data, pix_idx and frame_pixels hold their value until the next load.

Optional Feature:
- Macro: WS2812_RX_PASSTHRU_EN.
- Defined: adds output dout (1 bit), mimicking a real chained pixel. dout = 0 while the first pixel of a frame is being received. Once pix_valid for pixel 0 has fired, dout follows ds delayed by 1 clk for the rest of the frame. dout is forced 0 from the frame_done or err cycle onward, and on rst.
- Undefined: no dout port and no pass-through logic.

Test Plan:
- Single pixel, one '1' bit = 12 cycles high then 4 low; one '0' bit = 4 high then 12 low. Send word 0x00FF00, then 700 low cycles. Expect: pix_valid once with pix_data=0x00FF00 and pix_idx=0; frame_done once with frame_pixels=1; err never asserted.
- Sixty pixels of 0x240048, then a gap. Expect: 60 pix_valid strobes with pix_idx 0..59; frame_pixels=60.
- Glitch: a 1-cycle high pulse mid-word. Expect: err pulse; no pix_valid until a 600-cycle gap has passed and a fresh frame begins.
- Truncated frame: 10 bits, then a gap. Expect: frame_done and err on the same cycle; frame_pixels=0.
- Power-up mid-stream: release rst while din is toggling bits. Expect: nothing decoded until the first gap, then the next frame decodes correctly.
- With WS2812_RX_PASSTHRU_EN: two pixels, 0x0000FF then 0xFF0000. Expect: dout low for the first 24 bits; the second pixel's waveform reproduced on dout.
